// File: rtl/wash_cycle_ctrl.sv
// wash_cycle_ctrl: washing-machine main sequencer.
// Phase order: coin -> FILL -> WASH -> RINSE -> (optional extra WASH/RINSE passes) -> SPIN -> IDLE.
// It drives the minute counter's enable and clear, and consumes the counter's terminal pulses.
// Optional door interlock: define DOOR_INTERLOCK_EN to gate coin acceptance and phase progress on door_open.
module wash_cycle_ctrl #(
    parameter int DOUBLE_PASSES = 2,
    parameter int STATE_W       = 3
) (
    input  logic               CTRL_CLK,
    input  logic               CTRL_RST,
    input  logic               coin_in,
    input  logic               double_wash,
    input  logic               timer_pause,
    input  logic               door_open,
    input  logic               one_min,
    input  logic               Two_min,
    input  logic               five_min,
    output logic               CNT_en,
    output logic               CNT_done,
    output logic [STATE_W-1:0] state_o,
    output logic [1:0]         pass_cnt_o,
    output logic               wash_done,
    output logic               door_lock
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FILL  = 3'd1,
        WASH  = 3'd2,
        RINSE = 3'd3,
        SPIN  = 3'd4
    } state_t;

    state_t     state_r;
    state_t     next_state_s;
    logic       dbl_latched_r;
    logic [1:0] pass_cnt_r;
    logic       wash_done_r;

    logic       run_s;        // door permits phase progress
    logic       coin_ok_s;    // door permits a coin to start the cycle
    logic       start_s;      // coin accepted this cycle
    logic       pass_inc_s;   // rinse finished this cycle
    logic       set_done_s;   // spin finished this cycle
    logic [2:0] pass_next_s;
    logic       more_pass_s;

`ifdef DOOR_INTERLOCK_EN
    assign run_s     = ~door_open;
    assign coin_ok_s = ~door_open;
    assign door_lock = (state_r != IDLE);
`else
    logic door_unused_s;
    assign door_unused_s = door_open;
    assign run_s         = 1'b1;
    assign coin_ok_s     = 1'b1;
    assign door_lock     = 1'b0;
`endif

    // Pass count after the rinse currently in progress finishes, and whether another wash pass follows.
    assign pass_next_s = {1'b0, pass_cnt_r} + 3'd1;
    assign more_pass_s = dbl_latched_r && (pass_next_s < 3'(DOUBLE_PASSES));

    // Next-state logic plus the Mealy counter enable and clear for the current phase.
    always_comb begin
        next_state_s = state_r;
        CNT_en       = 1'b0;
        CNT_done     = 1'b0;
        start_s      = 1'b0;
        pass_inc_s   = 1'b0;
        set_done_s   = 1'b0;
        case (state_r)
            IDLE: begin
                CNT_done = 1'b1;
                if (coin_in && coin_ok_s) begin
                    next_state_s = FILL;
                    start_s      = 1'b1;
                end else begin
                    next_state_s = IDLE;
                end
            end
            FILL: begin
                CNT_en = run_s;
                if (run_s && one_min) begin
                    CNT_done     = 1'b1;
                    next_state_s = WASH;
                end else begin
                    next_state_s = FILL;
                end
            end
            WASH: begin
                CNT_en = run_s;
                if (run_s && five_min) begin
                    CNT_done     = 1'b1;
                    next_state_s = RINSE;
                end else begin
                    next_state_s = WASH;
                end
            end
            RINSE: begin
                CNT_en = run_s;
                if (run_s && Two_min) begin
                    CNT_done     = 1'b1;
                    pass_inc_s   = 1'b1;
                    next_state_s = more_pass_s ? WASH : SPIN;
                end else begin
                    next_state_s = RINSE;
                end
            end
            SPIN: begin
                CNT_en = run_s && !timer_pause;
                if (run_s && !timer_pause && one_min) begin
                    CNT_done     = 1'b1;
                    set_done_s   = 1'b1;
                    next_state_s = IDLE;
                end else begin
                    next_state_s = SPIN;
                end
            end
            default: begin
                next_state_s = IDLE;
            end
        endcase
    end

    // State register and cycle bookkeeping (double-wash latch, pass count, done flag).
    always_ff @(posedge CTRL_CLK) begin
        if (CTRL_RST) begin
            state_r       <= IDLE;
            dbl_latched_r <= 1'b0;
            pass_cnt_r    <= 2'd0;
            wash_done_r   <= 1'b0;
        end else begin
            state_r <= next_state_s;
            if (start_s) begin
                dbl_latched_r <= double_wash;
                pass_cnt_r    <= 2'd0;
                wash_done_r   <= 1'b0;
            end else begin
                if (pass_inc_s) begin
                    pass_cnt_r <= (pass_cnt_r == 2'd3) ? 2'd3 : pass_next_s[1:0];
                end
                if (set_done_s) begin
                    wash_done_r <= 1'b1;
                end
            end
        end
    end

    assign state_o    = STATE_W'(state_r);
    assign pass_cnt_o = pass_cnt_r;
    assign wash_done  = wash_done_r;

endmodule

// File: tb/tb_wash_cycle_ctrl.sv
// Scoreboard bench for wash_cycle_ctrl: the stimulus process pushes hand-computed per-cycle
// expectations, and a monitor on the falling edge pops them and compares them with the DUT outputs.
module tb_wash_cycle_ctrl;

    logic       CTRL_CLK = 1'b0;
    logic       CTRL_RST = 1'b1;
    logic       coin_in = 1'b0, double_wash = 1'b0, timer_pause = 1'b0, door_open = 1'b0;
    logic       one_min = 1'b0, Two_min = 1'b0, five_min = 1'b0;
    logic       CNT_en, CNT_done, wash_done, door_lock;
    logic [2:0] state_o;
    logic [1:0] pass_cnt_o;

    typedef struct packed {
        logic [2:0] st;
        logic       en;
        logic       dn;
        logic [1:0] pc;
        logic       wd;
        logic       lk;
    } exp_t;

    exp_t  exp_q[$];
    string name_q[$];
    int    tests_run = 0;
    int    tests_failed = 0;

    wash_cycle_ctrl #(.DOUBLE_PASSES(2), .STATE_W(3)) dut (
        .CTRL_CLK(CTRL_CLK), .CTRL_RST(CTRL_RST), .coin_in(coin_in), .double_wash(double_wash),
        .timer_pause(timer_pause), .door_open(door_open), .one_min(one_min), .Two_min(Two_min),
        .five_min(five_min), .CNT_en(CNT_en), .CNT_done(CNT_done), .state_o(state_o),
        .pass_cnt_o(pass_cnt_o), .wash_done(wash_done), .door_lock(door_lock)
    );

    always #5 CTRL_CLK = ~CTRL_CLK;

    // Drive one cycle of inputs just after the rising edge and queue the outputs expected in that cycle.
    task automatic step(input logic rst, input logic coin, input logic dbl, input logic pause,
                        input logic door, input logic om, input logic tm, input logic fm,
                        input logic [2:0] est, input logic een, input logic edn,
                        input logic [1:0] epc, input logic ewd, input string name);
        exp_t e;
        @(posedge CTRL_CLK);
        #1;
        CTRL_RST = rst; coin_in = coin; double_wash = dbl; timer_pause = pause;
        door_open = door; one_min = om; Two_min = tm; five_min = fm;
        e.st = est; e.en = een; e.dn = edn; e.pc = epc; e.wd = ewd;
`ifdef DOOR_INTERLOCK_EN
        e.lk = (est != 3'd0);
`else
        e.lk = 1'b0;
`endif
        exp_q.push_back(e);
        name_q.push_back(name);
    endtask

    // Quiet cycles with no pulses; the counter clear is high only while idle.
    task automatic hold(input int n, input logic [2:0] est, input logic een,
                        input logic [1:0] epc, input logic ewd, input string name);
        for (int i = 0; i < n; i++)
            step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                 est, een, (est == 3'd0), epc, ewd, name);
    endtask

    // Monitor: compare every queued expectation against the outputs in the middle of its cycle.
    always @(negedge CTRL_CLK) begin
        if (exp_q.size() > 0) begin
            exp_t  e;
            string n;
            e = exp_q.pop_front();
            n = name_q.pop_front();
            tests_run++;
            if (state_o !== e.st || CNT_en !== e.en || CNT_done !== e.dn ||
                pass_cnt_o !== e.pc || wash_done !== e.wd || door_lock !== e.lk) begin
                tests_failed++;
                $display("FAIL %s: got st=%0d en=%0b dn=%0b pc=%0d wd=%0b lk=%0b want st=%0d en=%0b dn=%0b pc=%0d wd=%0b lk=%0b",
                         n, state_o, CNT_en, CNT_done, pass_cnt_o, wash_done, door_lock,
                         e.st, e.en, e.dn, e.pc, e.wd, e.lk);
            end
        end
    end

    initial begin
        //    rst  coin dbl  pse  door om   tm   fm    st    en   dn   pc    wd
        step(1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0, 3'd0,1'b0,1'b1,2'd0,1'b0, "rst_hold");
        step(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0, 3'd0,1'b0,1'b1,2'd0,1'b0, "reset_state");

        // Single wash with pause, stray pulses and ignored inputs along the way.
        step(1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0, 3'd0,1'b0,1'b1,2'd0,1'b0, "idle_coin");
        hold(3, 3'd1, 1'b1, 2'd0, 1'b0, "fill_wait");
        step(1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,1'b0, 3'd1,1'b1,1'b1,2'd0,1'b0, "fill_pulse");
        hold(3, 3'd2, 1'b1, 2'd0, 1'b0, "wash_wait");
        step(1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0, 3'd2,1'b1,1'b0,2'd0,1'b0, "wash_pause_ignored");
        step(1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b1,1'b0, 3'd2,1'b1,1'b0,2'd0,1'b0, "wash_stray_pulses");
        step(1'b0,1'b1,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0, 3'd2,1'b1,1'b0,2'd0,1'b0, "wash_coin_ignored");
        step(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1, 3'd2,1'b1,1'b1,2'd0,1'b0, "wash_pulse");
        hold(3, 3'd3, 1'b1, 2'd0, 1'b0, "rinse_wait");
        step(1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,1'b1, 3'd3,1'b1,1'b0,2'd0,1'b0, "rinse_stray_pulses");
        step(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0, 3'd3,1'b1,1'b1,2'd0,1'b0, "rinse_pulse");
        hold(3, 3'd4, 1'b1, 2'd1, 1'b0, "spin_wait");
        step(1'b0,1'b0,1'b0,1'b1,1'b0,1'b1,1'b0,1'b0, 3'd4,1'b0,1'b0,2'd1,1'b0, "spin_paused_pulse");
        step(1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0, 3'd4,1'b0,1'b0,2'd1,1'b0, "spin_paused_hold");
        step(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b1, 3'd4,1'b1,1'b0,2'd1,1'b0, "spin_stray_pulses");
        step(1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,1'b0, 3'd4,1'b1,1'b1,2'd1,1'b0, "spin_pulse");
        hold(3, 3'd0, 1'b0, 2'd1, 1'b1, "idle_after_single");

        // Double wash: double_wash held one extra cycle after acceptance, then dropped.
        step(1'b0,1'b1,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0, 3'd0,1'b0,1'b1,2'd1,1'b1, "dbl_coin");
        step(1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0, 3'd1,1'b1,1'b0,2'd0,1'b0, "dbl_fill_cleared");
        hold(2, 3'd1, 1'b1, 2'd0, 1'b0, "dbl_fill_wait");
        step(1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,1'b0, 3'd1,1'b1,1'b1,2'd0,1'b0, "dbl_fill_pulse");
        hold(3, 3'd2, 1'b1, 2'd0, 1'b0, "dbl_wash1_wait");
        step(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1, 3'd2,1'b1,1'b1,2'd0,1'b0, "dbl_wash1_pulse");
        hold(3, 3'd3, 1'b1, 2'd0, 1'b0, "dbl_rinse1_wait");
        step(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0, 3'd3,1'b1,1'b1,2'd0,1'b0, "dbl_rinse1_pulse");
        hold(3, 3'd2, 1'b1, 2'd1, 1'b0, "dbl_wash2_wait");
        step(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1, 3'd2,1'b1,1'b1,2'd1,1'b0, "dbl_wash2_pulse");
        hold(3, 3'd3, 1'b1, 2'd1, 1'b0, "dbl_rinse2_wait");
        step(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0, 3'd3,1'b1,1'b1,2'd1,1'b0, "dbl_rinse2_pulse");
        hold(3, 3'd4, 1'b1, 2'd2, 1'b0, "dbl_spin_wait");
        step(1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,1'b0, 3'd4,1'b1,1'b1,2'd2,1'b0, "dbl_spin_pulse");
        hold(2, 3'd0, 1'b0, 2'd2, 1'b1, "idle_after_double");

        // Reset in the second wash pass aborts the cycle.
        step(1'b0,1'b1,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0, 3'd0,1'b0,1'b1,2'd2,1'b1, "rst_coin");
        hold(1, 3'd1, 1'b1, 2'd0, 1'b0, "rst_fill");
        step(1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,1'b0, 3'd1,1'b1,1'b1,2'd0,1'b0, "rst_fill_pulse");
        step(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1, 3'd2,1'b1,1'b1,2'd0,1'b0, "rst_wash1_pulse");
        step(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0, 3'd3,1'b1,1'b1,2'd0,1'b0, "rst_rinse1_pulse");
        hold(2, 3'd2, 1'b1, 2'd1, 1'b0, "rst_wash2");
        step(1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0, 3'd2,1'b1,1'b0,2'd1,1'b0, "rst_in_wash");
        step(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0, 3'd0,1'b0,1'b1,2'd0,1'b0, "after_rst");
        hold(2, 3'd0, 1'b0, 2'd0, 1'b0, "idle_after_rst");

`ifdef DOOR_INTERLOCK_EN
        step(1'b0,1'b1,1'b0,1'b0,1'b1,1'b0,1'b0,1'b0, 3'd0,1'b0,1'b1,2'd0,1'b0, "coin_door_open");
        step(1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0, 3'd0,1'b0,1'b1,2'd0,1'b0, "coin_door_closed");
        step(1'b0,1'b0,1'b0,1'b0,1'b1,1'b1,1'b0,1'b0, 3'd1,1'b0,1'b0,2'd0,1'b0, "fill_door_open_pulse");
        step(1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,1'b0, 3'd1,1'b0,1'b0,2'd0,1'b0, "fill_door_open_hold");
        step(1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,1'b0, 3'd1,1'b1,1'b1,2'd0,1'b0, "fill_door_closed_pulse");
        step(1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,1'b1, 3'd2,1'b0,1'b0,2'd0,1'b0, "wash_door_open_pulse");
        step(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1, 3'd2,1'b1,1'b1,2'd0,1'b0, "wash_door_closed_pulse");
        step(1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0, 3'd3,1'b1,1'b0,2'd0,1'b0, "door_rst_in_rinse");
        step(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0, 3'd0,1'b0,1'b1,2'd0,1'b0, "door_after_rst");
`endif

        repeat (3) @(posedge CTRL_CLK);
        tests_run++;
        if (exp_q.size() != 0) begin
            tests_failed++;
            $display("FAIL scoreboard_drain: got %0d pending want 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/wash_cycle_ctrl.md
Name: wash_cycle_ctrl

Overview:
- Washing-machine main controller FSM.
- Sits directly upstream of the minutes/wash-times counter: drives its CNT_en and CNT_done, and consumes its one_min, Two_min and five_min terminal pulses.
- Sequences coin start -> fill -> wash -> rinse -> (optional second wash+rinse) -> spin -> idle.
- Supports timer pause during spin and reports a registered done flag.

Parameters:
- DOUBLE_PASSES, 2, number of wash+rinse passes when double wash is selected (1..3).
- STATE_W, 3, width of the state_o encoding.

Ports:
- CTRL_CLK  input  1  system clock, rising edge.
- CTRL_RST  input  1  reset; synchronous, active-high.
- coin_in  input  1  start request; level-sampled in IDLE.
- double_wash  input  1  double-wash select; sampled on coin acceptance.
- timer_pause  input  1  pause request; honoured only in SPIN.
- door_open  input  1  door sensor; used only with DOOR_INTERLOCK_EN.
- one_min  input  1  counter pulse: 1 minute elapsed in current phase.
- Two_min  input  1  counter pulse: 2 minutes elapsed.
- five_min  input  1  counter pulse: 5 minutes elapsed.
- CNT_en  output  1  counter run enable.
- CNT_done  output  1  counter clear (minutes/clocks).
- state_o  output  STATE_W  current state code.
- pass_cnt_o  output  2  wash passes completed in the current cycle.
- wash_done  output  1  cycle complete flag.
- door_lock  output  1  door lock actuator.

Behaviour:
- Reset: synchronous. CTRL_RST high at a rising edge forces state=IDLE, pass_cnt_o=0, wash_done=0 and dbl_latched=0, from any state including mid-cycle. Asserting reset mid-cycle aborts the cycle and does not set wash_done.
- State encoding: IDLE=0, FILL=1, WASH=2, RINSE=3, SPIN=4. Codes 5-7 are illegal and recover to IDLE on the next clock.
- IDLE: CNT_en=0, CNT_done=1.
  - coin_in=1 -> FILL next cycle.
  - On that transition: dbl_latched<=double_wash, pass_cnt_o<=0, wash_done<=0.
- FILL: CNT_en=1. one_min -> WASH.
- WASH: CNT_en=1. five_min -> RINSE.
- RINSE: CNT_en=1. Two_min -> pass_cnt_o<=pass_cnt_o+1, then:
  - go to WASH if dbl_latched && (pass_cnt_o+1)<DOUBLE_PASSES;
  - otherwise go to SPIN.
- SPIN: CNT_en=!timer_pause. one_min && CNT_en -> IDLE, wash_done<=1.
- CNT_done (combinational, Mealy):
  - 1 in IDLE;
  - 1 in the cycle where the current state's terminal pulse is accepted, so the counter restarts at 0 in the first cycle of the next phase;
  - 0 otherwise.
- Terminal pulses are accepted only in the matching state and only when CNT_en=1. Pulses not matching the current state are ignored.
- Simultaneous pulses: only the matching pulse matters.
- Latency: one clock from accepted terminal pulse to new state_o.
- Pause: timer_pause in FILL/WASH/RINSE is ignored. In SPIN, CNT_en drops in the same cycle timer_pause is high, the counter holds, and the state holds.
- coin_in and double_wash are ignored outside IDLE. double_wash changes after acceptance have no effect.
- pass_cnt_o saturates at 3 and holds its value in IDLE until the next coin.
- wash_done stays high until the next accepted coin or reset.
- door_lock=0 unless DOOR_INTERLOCK_EN is defined.

Optional Feature:
- Macro: DOOR_INTERLOCK_EN.
- Defined:
  - In IDLE, coin_in is accepted only when door_open=0.
  - In FILL/WASH/RINSE/SPIN, door_open=1 forces CNT_en=0 (phase frozen, no pulses accepted) and state holds.
  - door_lock=1 in every non-IDLE state, 0 in IDLE.
- Undefined: door_open is ignored and door_lock is tied 0.

Test Plan:
- Reset mid-WASH: pulse CTRL_RST for 1 clock -> next cycle state_o=0, CNT_en=0, CNT_done=1, pass_cnt_o=0, wash_done=0.
- Single wash: coin_in=1, double_wash=0; then one_min, five_min, Two_min, one_min, each after ≥3 idle clocks -> states 1,2,3,4,0; CNT_done high exactly on each pulse cycle; pass_cnt_o=1; wash_done=1.
- Double wash, DOUBLE_PASSES=2:
  - coin with double_wash=1; drop double_wash after one cycle.
  - Full pulse sequence -> state path 1,2,3,2,3,4,0.
  - pass_cnt_o=2 at end.
- Spin pause: in SPIN hold timer_pause=1 and inject one_min -> CNT_en=0, state stays 4, pulse ignored. Release pause and inject one_min -> IDLE, wash_done=1.
- Stray pulses: in WASH inject one_min and Two_min -> state stays 2, CNT_done stays 0. Then five_min -> RINSE.
- With DOOR_INTERLOCK_EN:
  - coin_in=1 with door_open=1 -> stays IDLE.
  - door_open=0 -> FILL, door_lock=1.
  - door_open=1 in FILL plus one_min -> CNT_en=0, stays FILL.
